// File: rtl/redux_pkg.sv
// redux_pkg: shared widths, defaults and dump-FSM state encoding for the ReduxV datapath
package redux_pkg;
  localparam int LARGURA_DADO = 8;
  localparam int LARGURA_END = 2;
  localparam int N_REG = 4;
  localparam int CICLOS_BIT_PADRAO = 4;
  typedef enum logic [2:0] {OCIOSO, LE, BIT_INICIO, DADOS, PARADA} estado_t;
endpackage

// File: rtl/banco_registradores.sv
// banco_registradores: 4x8 register bank, async read ports ra/rb, write to rb when rw
module banco_registradores
  import redux_pkg::*;
(
  input  logic                    clk,
  input  logic                    rw,
  input  logic [LARGURA_END-1:0]  ra,
  input  logic [LARGURA_END-1:0]  rb,
  input  logic [LARGURA_DADO-1:0] dado,
  output logic [LARGURA_DADO-1:0] s_ra,
  output logic [LARGURA_DADO-1:0] s_rb
);
  logic [LARGURA_DADO-1:0] regs [N_REG];
  always_ff @(posedge clk)
    if (rw) regs[rb] <= dado;
  assign s_ra = regs[ra];
  assign s_rb = regs[rb];
endmodule

// File: rtl/despejo_banco_contador_bit.sv
// contador_bit: 0..CICLOS_BIT-1 wrap counter with clear; fim marks the last cycle of a bit
module contador_bit #(
  parameter int CICLOS_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic limpa,
  output logic fim
);
  localparam int W = CICLOS_BIT > 1 ? $clog2(CICLOS_BIT) : 1;
  logic [W-1:0] cnt;
  assign fim = cnt == W'(CICLOS_BIT - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else cnt <= (limpa || fim) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/despejo_banco.sv
// despejo_banco: walks the register bank via ra and sends each value as a UART-style frame on tx
module despejo_banco
  import redux_pkg::*;
#(
  parameter int CICLOS_BIT = CICLOS_BIT_PADRAO,
  parameter int N_REG = redux_pkg::N_REG
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    inicio,
  input  logic [LARGURA_DADO-1:0] s_ra,
  output logic [LARGURA_END-1:0]  ra,
  output logic                    tx,
  output logic                    ocupado,
  output logic                    feito
);
  estado_t estado, prox;
  logic [LARGURA_DADO-1:0] sr, sr_n;
  logic [2:0] nbit, nbit_n;
  logic [LARGURA_END-1:0] idx_n;
  logic fim, tx_n, feito_n;
  // the bit timer restarts at every frame so start/data/stop phases stay aligned to it
  contador_bit #(.CICLOS_BIT(CICLOS_BIT)) u_cnt (
    .clk,
    .reset,
    .limpa(estado == OCIOSO || estado == LE),
    .fim
  );
  assign ocupado = estado != OCIOSO;
  always_comb begin
    prox = estado;
    sr_n = sr;
    nbit_n = nbit;
    idx_n = ra;
    feito_n = 1'b0;
    case (estado)
      OCIOSO: if (inicio) begin
        prox = LE;
        idx_n = '0;
      end
      LE: begin
        sr_n = s_ra;
        prox = BIT_INICIO;
      end
      BIT_INICIO: if (fim) prox = DADOS;
      DADOS: if (fim) begin
        sr_n = sr >> 1;
        nbit_n = nbit + 3'd1;
        if (nbit == 3'd7) prox = PARADA;
      end
      PARADA: if (fim) begin
        if (ra < LARGURA_END'(N_REG - 1)) begin
          idx_n = ra + 1'b1;
          prox = LE;
        end else begin
          prox = OCIOSO;
          feito_n = 1'b1;
        end
      end
      default: prox = OCIOSO;
    endcase
    // tx follows the state being entered so it changes on the same edge as the state
    tx_n = prox == BIT_INICIO ? 1'b0 : prox == DADOS ? sr_n[0] : 1'b1;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      estado <= OCIOSO;
      sr <= '0;
      nbit <= '0;
      ra <= '0;
      tx <= 1'b1;
      feito <= 1'b0;
    end else begin
      estado <= prox;
      sr <= sr_n;
      nbit <= nbit_n;
      ra <= idx_n;
      tx <= tx_n;
      feito <= feito_n;
    end
endmodule

// File: tb/tb_despejo_banco.sv
// tb_despejo_banco: dumps real register banks through CICLOS_BIT=4 and =1 instances against a frame-level model
module tb_despejo_banco;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  logic ini [2];
  logic rw [2];
  logic [1:0] rb [2];
  logic [7:0] dado [2];
  wire [7:0] sra4, sra1, srb4, srb1;
  wire [1:0] ra4, ra1;
  wire tx4, tx1, oc4, oc1, fe4, fe1;
  int checks = 0;
  int errors = 0;

  despejo_banco #(.CICLOS_BIT(4)) u4 (.clk, .reset, .inicio(ini[0]), .s_ra(sra4), .ra(ra4), .tx(tx4), .ocupado(oc4), .feito(fe4));
  banco_registradores b4 (.clk, .rw(rw[0]), .ra(ra4), .rb(rb[0]), .dado(dado[0]), .s_ra(sra4), .s_rb(srb4));
  despejo_banco #(.CICLOS_BIT(1)) u1 (.clk, .reset, .inicio(ini[1]), .s_ra(sra1), .ra(ra1), .tx(tx1), .ocupado(oc1), .feito(fe1));
  banco_registradores b1 (.clk, .rw(rw[1]), .ra(ra1), .rb(rb[1]), .dado(dado[1]), .s_ra(sra1), .s_rb(srb1));

  typedef struct {
    int i;
    logic [3:0][7:0] r;
    logic [3:0][7:0] e;
    int dur;
    string nm;
  } vec_t;
  vec_t tbl [3];
  localparam logic [3:0][7:0] PADRAO = {8'hFF, 8'h00, 8'hA3, 8'h05};

  task automatic chk(input bit ok, input string nm, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic smp(input int i, output logic t, output logic o, output logic f, output logic [1:0] a);
    if (i == 0) begin
      t = tx4; o = oc4; f = fe4; a = ra4;
    end else begin
      t = tx1; o = oc1; f = fe1; a = ra1;
    end
  endtask

  task automatic load(input int i, input logic [3:0][7:0] v);
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      rb[i] = 2'(r); dado[i] = v[r]; rw[i] = 1'b1;
    end
    @(negedge clk);
    rw[i] = 1'b0;
    for (int r = 0; r < 4; r++) begin
      rb[i] = 2'(r);
      #1;
      chk((i == 0 ? srb4 : srb1) == v[r], "bank_load", i == 0 ? srb4 : srb1, v[r]);
    end
  endtask

  task automatic start(input int i);
    @(negedge clk);
    ini[i] = 1'b1;
    @(negedge clk);
  endtask

  // Called in cycle 1 of a dump; model is the frame list built straight from the expected bytes
  task automatic observe(input int i, input logic [3:0][7:0] exp, input bit keep, input bit busy,
                         input bit wr, input string nm, output int dur);
    int c = i == 0 ? 4 : 1;
    int per = 1 + 10 * c;
    int tot = 4 * per;
    bit wav [$];
    bit tx_s [$];
    int bad_tx = 0, bad_ra = 0, bad_oc = 0, first = -1;
    logic t, o, f;
    logic [1:0] a;
    logic [7:0] d;
    dur = -1;
    for (int r = 0; r < 4; r++) begin
      wav.push_back(1'b1);
      repeat (c) wav.push_back(1'b0);
      for (int b = 0; b < 8; b++) repeat (c) wav.push_back(exp[r][b]);
      repeat (c) wav.push_back(1'b1);
    end
    for (int k = 0; k < 500 && dur < 0; k++) begin
      smp(i, t, o, f, a);
      if (f) dur = k;
      else begin
        if (k < tot) begin
          if (t !== wav[k]) begin bad_tx++; if (first < 0) first = k; end
          if (a !== 2'(k / per)) bad_ra++;
        end
        if (o !== 1'b1) bad_oc++;
        tx_s.push_back(t);
      end
      if (busy) ini[i] = (k == 9 || k == 99);
      else if (!keep) ini[i] = 1'b0;
      if (wr) begin
        rw[i] = (k == 20 || k == 60);
        rb[i] = k == 20 ? 2'd1 : 2'd0;
        dado[i] = k == 20 ? 8'h3C : 8'h77;
      end
      if (dur < 0) @(negedge clk);
    end
    chk(dur == tot, {nm, "_dur"}, dur, tot);
    chk(bad_tx == 0, {nm, "_tx_wave"}, first, -1);
    chk(bad_ra == 0, {nm, "_ra_seq"}, bad_ra, 0);
    chk(bad_oc == 0, {nm, "_ocupado"}, bad_oc, 0);
    chk(o === 1'b0 && t === 1'b1, {nm, "_end_idle"}, {o, t}, 2'b01);
    for (int r = 0; r < 4; r++) begin
      int base = r * per + 1 + c / 2;
      d = 'x;
      if (base + 9 * c < tx_s.size()) begin
        for (int b = 0; b < 8; b++) d[b] = tx_s[base + c * (1 + b)];
        chk(tx_s[base] == 1'b0 && tx_s[base + 9 * c] == 1'b1, {nm, "_start_stop"},
            {tx_s[base], tx_s[base + 9 * c]}, 2'b01);
      end
      chk(d === exp[r], {nm, "_byte"}, d, exp[r]);
    end
    if (!keep) begin
      @(negedge clk);
      smp(i, t, o, f, a);
      chk(!f && !o && t && a == 2'd3, {nm, "_after"}, {f, o, t, a}, 5'b00111);
    end
  endtask

  initial begin
    int dur;
    logic t, o, f;
    logic [1:0] a;
    logic [3:0][7:0] v;
    tbl[0].i = 0; tbl[0].r = PADRAO; tbl[0].e = {8'hFF, 8'h00, 8'hA3, 8'h05}; tbl[0].dur = 164; tbl[0].nm = "full4";
    tbl[1].i = 1; tbl[1].r = PADRAO; tbl[1].e = {8'hFF, 8'h00, 8'hA3, 8'h05}; tbl[1].dur = 44; tbl[1].nm = "full1";
    tbl[2].i = 0; tbl[2].r = {8'h80, 8'h01, 8'hAA, 8'h55}; tbl[2].e = {8'h80, 8'h01, 8'hAA, 8'h55}; tbl[2].dur = 164; tbl[2].nm = "alt4";
    for (int i = 0; i < 2; i++) begin
      ini[i] = 1'b0; rw[i] = 1'b0; rb[i] = 2'd0; dado[i] = 8'h00;
    end
    reset = 1'b1;
    #1;
    chk(tx4 && !oc4 && !fe4 && ra4 == 2'd0, "reset4", {tx4, oc4, fe4, ra4}, 5'b10000);
    chk(tx1 && !oc1 && !fe1 && ra1 == 2'd0, "reset1", {tx1, oc1, fe1, ra1}, 5'b10000);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    foreach (tbl[n]) begin
      load(tbl[n].i, tbl[n].r);
      start(tbl[n].i);
      observe(tbl[n].i, tbl[n].e, 1'b0, 1'b0, 1'b0, tbl[n].nm, dur);
      chk(dur == tbl[n].dur, {tbl[n].nm, "_table_dur"}, dur, tbl[n].dur);
    end

    load(0, PADRAO);
    start(0);
    observe(0, PADRAO, 1'b0, 1'b1, 1'b0, "busy", dur);
    repeat (5) begin
      @(negedge clk);
      chk(!oc4 && !fe4, "busy_no_second", {oc4, fe4}, 0);
    end

    @(negedge clk);
    ini[0] = 1'b1;
    @(negedge clk);
    observe(0, PADRAO, 1'b1, 1'b0, 1'b0, "held1", dur);
    @(negedge clk);
    observe(0, PADRAO, 1'b0, 1'b0, 1'b0, "held2", dur);

    load(0, PADRAO);
    start(0);
    observe(0, {8'hFF, 8'h00, 8'h3C, 8'h05}, 1'b0, 1'b0, 1'b1, "write", dur);

    load(0, PADRAO);
    start(0);
    ini[0] = 1'b0;
    repeat (49) @(negedge clk);
    smp(0, t, o, f, a);
    chk(o && a == 2'd1, "pre_reset_busy", {o, a}, 3'b101);
    reset = 1'b1;
    #1;
    chk(tx4 && !oc4 && !fe4 && ra4 == 2'd0, "reset_async", {tx4, oc4, fe4, ra4}, 5'b10000);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk(tx4 && !oc4 && !fe4, "reset_idle", {tx4, oc4, fe4}, 3'b100);
    end
    start(0);
    observe(0, PADRAO, 1'b0, 1'b0, 1'b0, "restart", dur);

    repeat (6) begin
      int i = int'($urandom_range(0, 1));
      for (int r = 0; r < 4; r++) v[r] = 8'($urandom);
      load(i, v);
      start(i);
      observe(i, v, 1'b0, 1'b0, 1'b0, i == 0 ? "rand4" : "rand1", dur);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
